seg_scan_driver: RTL and testbench
==================================

// Module: seg_scan_driver
// PURPOSE
//  Time-multiplexed 7-segment display driver, downstream of the counter stages.
//  Captures a packed hex value on a load strobe and shows it on the board's
//  common-anode digits, scanning one digit at a time.
//  Buffers loads and applies them only at frame boundaries, so the display
//  never shows a mix of old and new digits.
// PARAMETERS
//  DIGITS    4        number of digits scanned, legal 1..8
//  SCAN_DIV  100000   CLK cycles each digit stays lit, >=2
// PORTS
//  CLK         in   1          system clock; all logic on posedge
//  rst         in   1          synchronous, active-high reset
//  load        in   1          1-cycle strobe; captures din
//  din         in   4*DIGITS   packed hex digits; din[3:0] = digit 0 (rightmost)
//  blank       in   DIGITS     1 = force that digit dark; sampled live, not latched
//  an          out  DIGITS     digit enables, active-low, one-hot-low
//  seg         out  7          {g,f,e,d,c,b,a}, active-low (0 = lit)
//  frame_done  out  1          1-cycle pulse when the last digit's slot ends
// BEHAVIOUR
//  Reset, synchronous: all outputs and state clear on the next CLK edge while rst=1.
//   - an = all 1s; seg = 7'h7F; frame_done = 0
//   - prescaler = 0; digit index = 0
//   - shadow = 0; display register = 0; pending = 0
//  Prescaler: counts 0..SCAN_DIV-1, then wraps to 0.
//   - The wrap cycle is "tick".
//   - On tick, digit index advances 0,1,...,DIGITS-1 and then back to 0.
//  Load:
//   - When load=1, shadow <= din and pending <= 1 on that edge.
//   - A later load before the frame boundary overwrites shadow; the last one wins.
//  Frame boundary: tick while index == DIGITS-1.
//   - frame_done pulses for that cycle.
//   - If pending, display register <= shadow and pending <= 0 on that edge.
//   - load and boundary in the same cycle: display takes the old shadow;
//     the new din goes to shadow with pending=1, applied at the next boundary.
//  Outputs: registered, and change one cycle after the index changes.
//   - an[i] = 0 only for i == index.
//   - seg = hex decode of display nibble[index].
//   - blank[index]=1 forces seg = 7'h7F; an is still driven.
//  Hex decode, seg codes:
//   - 0=40  1=79  2=24  3=30  4=19  5=12  6=02  7=78
//   - 8=00  9=10  A=08  b=03  C=46  d=21  E=06  F=0E
//  Latency:
//   - load to first visible change: at most (DIGITS*SCAN_DIV + 1) cycles
//   - digit change: 1 cycle after tick
//  Reset mid-frame:
//   - an goes dark and any pending load is discarded
//   - scanning restarts at digit 0 showing "0"s
//  DIGITS=1: every tick is a frame boundary, so frame_done pulses every SCAN_DIV cycles.
// CONFIGURATION
//  LEAD_ZERO_BLANK_EN defined:
//   - A digit shows dark (seg=7'h7F) if its nibble and every higher nibble
//     of the display register are 0.
//   - Digit 0 is never blanked by this rule, so value 0 shows a single "0".
//  Not defined:
//   - All digits display, including leading zeros.
//   - No extra logic is present.
// TESTING (SCAN_DIV=4, DIGITS=4 unless noted)
//  1. rst held 3 cycles, then released
//     -> an=4'hF, seg=7F during reset;
//     -> then an=4'hE, seg=40 and an rotates E,D,B,7 every 4 cycles; frame_done every 16 cycles.
//  2. load din=16'h12AF mid-frame
//     -> display unchanged until frame_done;
//     -> next frame shows seg 0E,08,24,79 on digits 0..3.
//  3. load 16'h1111, then 16'h2222 before the boundary
//     -> only "2222" ever appears, never "1111".
//  4. load asserted on the boundary cycle with din=16'h3333
//     -> this frame shows the old shadow; the following frame shows "3333".
//  5. blank=4'b0100 with display 16'h8888
//     -> seg=7F while an=4'hB; digits 0, 1 and 3 show 00.
//  6. LEAD_ZERO_BLANK_EN defined, load 16'h0050
//     -> digits 3 and 2 dark, digit 1 shows 12, digit 0 shows 40;
//     -> load 16'h0000 -> only digit 0 shows 40.

Source files
------------

// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with frame-synchronous load.
// Latency: an/seg registered, change 1 CLK after the digit index advances.
// No backpressure: load is a 1-cycle strobe; a newer load overwrites a pending one.
//
// Ports:
//   CLK        - system clock, all logic on posedge
//   rst        - synchronous active-high reset
//   load       - 1-cycle strobe, captures din into the shadow register
//   din        - packed hex digits, din[3:0] is digit 0 (rightmost)
//   blank      - per-digit force-dark, sampled live
//   an         - digit enables, active-low, one-hot-low
//   seg        - {g,f,e,d,c,b,a}, active-low
//   frame_done - 1-cycle pulse during the last digit's final cycle
//
// Optional feature macro: LEAD_ZERO_BLANK_EN (leading-zero suppression).
module seg_scan_driver #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 100000
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   din,
  input  logic [DIGITS-1:0]     blank,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  frame_done
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PS_LAST  = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] PS_PRE   = PW'(SCAN_DIV - 2);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic [PW-1:0]         prescale;
  logic [IW-1:0]         idx;
  logic [4*DIGITS-1:0]   shadow;
  logic [4*DIGITS-1:0]   disp;
  logic                  pending;

  logic                  tick;
  logic                  boundary;
  logic                  pre_boundary;
  logic [3:0]            cur_nib;
  logic                  cur_blank;
  logic                  cur_dark;
  logic [DIGITS-1:0]     an_nxt;
  logic [6:0]            seg_nxt;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  assign tick     = (prescale == PS_LAST);
  assign boundary = tick && (idx == IDX_LAST);
  // frame_done is registered but must be high during the boundary cycle,
  // so it is launched one cycle early. SCAN_DIV >= 2 guarantees PS_PRE exists.
  assign pre_boundary = (prescale == PS_PRE) && (idx == IDX_LAST);

  // Select the nibble and live blank bit of the digit currently being scanned.
  always_comb begin
    cur_nib   = 4'h0;
    cur_blank = 1'b0;
    an_nxt    = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_nib   = disp[4*i +: 4];
        cur_blank = blank[i];
        an_nxt[i] = 1'b0;
      end
    end
  end

`ifdef LEAD_ZERO_BLANK_EN
  logic [DIGITS-1:0] lz_dark;
  logic              lz_run;
  logic              cur_lz;

  // A digit is dark when it and every higher nibble are zero; digit 0 never is.
  always_comb begin
    lz_dark = '0;
    lz_run  = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      lz_run     = lz_run && (disp[4*i +: 4] == 4'h0);
      lz_dark[i] = lz_run;
    end
  end

  always_comb begin
    cur_lz = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) cur_lz = lz_dark[i];
    end
  end

  assign cur_dark = cur_blank | cur_lz;
`else
  assign cur_dark = cur_blank;
`endif

  assign seg_nxt = cur_dark ? 7'h7F : hex7(cur_nib);

  always_ff @(posedge CLK) begin
    if (rst) begin
      prescale   <= '0;
      idx        <= '0;
      shadow     <= '0;
      disp       <= '0;
      pending    <= 1'b0;
      an         <= '1;
      seg        <= 7'h7F;
      frame_done <= 1'b0;
    end else begin
      prescale <= tick ? '0 : prescale + 1'b1;

      if (tick) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end

      // Boundary transfer first; a coincident load then re-arms pending
      // with the new value, so it lands one frame later.
      if (boundary && pending) begin
        disp    <= shadow;
        pending <= 1'b0;
      end
      if (load) begin
        shadow  <= din;
        pending <= 1'b1;
      end

      an         <= an_nxt;
      seg        <= seg_nxt;
      frame_done <= pre_boundary;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
module tb_seg_scan_driver;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;

  logic        CLK = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] din;
  logic [3:0]  blank;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
  } slot_t;

  slot_t      exp_q[$];
  logic [3:0] cap_an[4];
  logic [6:0] cap_seg[4];

  seg_scan_driver #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
    .CLK        (CLK),
    .rst        (rst),
    .load       (load),
    .din        (din),
    .blank      (blank),
    .an         (an),
    .seg        (seg),
    .frame_done (frame_done)
  );

  always #5 CLK = ~CLK;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input logic [15:0] val, input int k, input logic [3:0] blk);
    logic [3:0] nib;
    nib = val[4*k +: 4];
    if (blk[k]) return 7'h7F;
`ifdef LEAD_ZERO_BLANK_EN
    if (k != 0 && (val >> (4*k)) == 16'h0) return 7'h7F;
`endif
    return hex7(nib);
  endfunction

  function automatic int an2idx(input logic [3:0] a);
    for (int i = 0; i < 4; i++) if (!a[i]) return i;
    return 0;
  endfunction

  // Expected scan of one full frame, digit 0 first.
  task automatic push_frame(input logic [15:0] val, input logic [3:0] blk);
    slot_t s;
    for (int k = 0; k < 4; k++) begin
      s.an    = 4'hF;
      s.an[k] = 1'b0;
      s.seg   = exp_seg(val, k, blk);
      exp_q.push_back(s);
    end
  endtask

  task automatic wait_fd(output bit to);
    to = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge CLK);
      if (frame_done === 1'b1) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  // Samples the middle of each digit slot of the frame that follows a
  // frame_done seen first_wait negedges earlier.
  task automatic capture(input int first_wait);
    repeat (first_wait) @(negedge CLK);
    for (int k = 0; k < 4; k++) begin
      cap_an[k]  = an;
      cap_seg[k] = seg;
      if (k < 3) repeat (4) @(negedge CLK);
    end
  endtask

  task automatic pulse_load(input logic [15:0] val);
    din  = val;
    load = 1'b1;
    @(negedge CLK);
    load = 1'b0;
  endtask

  task automatic test_reset;
    logic [3:0] ea;
    logic [6:0] es;
    logic       ef;
    int         d;
    rst = 1'b1; load = 1'b0; din = '0; blank = '0;
    repeat (3) begin
      @(negedge CLK);
      checks++;
      if (an !== 4'hF || seg !== 7'h7F || frame_done !== 1'b0) begin
        errors++;
        $display("FAIL reset_state: an=%h seg=%h fd=%b, want an=F seg=7F fd=0", an, seg, frame_done);
      end
    end
    rst = 1'b0;
    for (int n = 1; n <= 32; n++) begin
      @(negedge CLK);
      d     = ((n - 1) / 4) % 4;
      ea    = 4'hF;
      ea[d] = 1'b0;
      es    = exp_seg(16'h0, d, 4'h0);
      ef    = (n == 15 || n == 31);
      checks++;
      if (an !== ea || seg !== es || frame_done !== ef) begin
        errors++;
        $display("FAIL scan_after_reset n=%0d: an=%h seg=%h fd=%b, want an=%h seg=%h fd=%b",
                 n, an, seg, frame_done, ea, es, ef);
      end
    end
  endtask

  task automatic test_load_mid_frame;
    bit    to;
    slot_t e;
    logic [6:0] es;
    repeat (2) @(negedge CLK);
    pulse_load(16'h12AF);
    to = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge CLK);
      es = exp_seg(16'h0, an2idx(an), blank);
      checks++;
      if (seg !== es) begin
        errors++;
        $display("FAIL load_hold: seg=%h an=%h, want seg=%h", seg, an, es);
      end
      if (frame_done === 1'b1) begin
        to = 1'b0;
        break;
      end
    end
    checks++;
    if (to) begin
      errors++;
      $display("FAIL load_hold_timeout: frame_done=0, want 1 within 64 cycles");
    end
    push_frame(16'h12AF, 4'h0);
    capture(3);
    for (int k = 0; k < 4; k++) begin
      e = exp_q.pop_front();
      checks++;
      if (cap_an[k] !== e.an || cap_seg[k] !== e.seg) begin
        errors++;
        $display("FAIL load_frame d%0d: an=%h seg=%h, want an=%h seg=%h", k, cap_an[k], cap_seg[k], e.an, e.seg);
      end
    end
  endtask

  task automatic test_blank;
    bit    to;
    slot_t e;
    pulse_load(16'h8888);
    wait_fd(to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL blank_timeout: frame_done=0, want 1");
    end
    blank = 4'b0100;
    push_frame(16'h8888, 4'b0100);
    capture(3);
    for (int k = 0; k < 4; k++) begin
      e = exp_q.pop_front();
      checks++;
      if (cap_an[k] !== e.an || cap_seg[k] !== e.seg) begin
        errors++;
        $display("FAIL blank_frame d%0d: an=%h seg=%h, want an=%h seg=%h", k, cap_an[k], cap_seg[k], e.an, e.seg);
      end
    end
    blank = 4'b0000;
  endtask

  task automatic test_last_wins;
    bit    to;
    slot_t e;
    wait_fd(to);
    repeat (3) @(negedge CLK);
    pulse_load(16'h1111);
    repeat (4) @(negedge CLK);
    pulse_load(16'h2222);
    to = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge CLK);
      checks++;
      if (seg === 7'h79) begin
        errors++;
        $display("FAIL last_wins_no_1111: seg=%h, want not 79", seg);
      end
      if (frame_done === 1'b1) begin
        to = 1'b0;
        break;
      end
    end
    checks++;
    if (to) begin
      errors++;
      $display("FAIL last_wins_timeout: frame_done=0, want 1");
    end
    for (int f = 0; f < 2; f++) begin
      if (f == 1) wait_fd(to);
      push_frame(16'h2222, 4'h0);
      capture(3);
      for (int k = 0; k < 4; k++) begin
        e = exp_q.pop_front();
        checks++;
        if (cap_an[k] !== e.an || cap_seg[k] !== e.seg) begin
          errors++;
          $display("FAIL last_wins_frame%0d d%0d: an=%h seg=%h, want an=%h seg=%h",
                   f, k, cap_an[k], cap_seg[k], e.an, e.seg);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    bit    to;
    slot_t e;
    wait_fd(to);
    repeat (3) @(negedge CLK);
    pulse_load(16'h4444);
    wait_fd(to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL boundary_timeout: frame_done=0, want 1");
    end
    // Load lands on the boundary edge itself.
    din  = 16'h3333;
    load = 1'b1;
    @(negedge CLK);
    load = 1'b0;
    push_frame(16'h4444, 4'h0);
    capture(2);
    for (int k = 0; k < 4; k++) begin
      e = exp_q.pop_front();
      checks++;
      if (cap_an[k] !== e.an || cap_seg[k] !== e.seg) begin
        errors++;
        $display("FAIL boundary_old d%0d: an=%h seg=%h, want an=%h seg=%h", k, cap_an[k], cap_seg[k], e.an, e.seg);
      end
    end
    wait_fd(to);
    push_frame(16'h3333, 4'h0);
    capture(3);
    for (int k = 0; k < 4; k++) begin
      e = exp_q.pop_front();
      checks++;
      if (cap_an[k] !== e.an || cap_seg[k] !== e.seg) begin
        errors++;
        $display("FAIL boundary_new d%0d: an=%h seg=%h, want an=%h seg=%h", k, cap_an[k], cap_seg[k], e.an, e.seg);
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    bit         to;
    slot_t      e;
    logic [3:0] ea;
    logic [6:0] es;
    pulse_load(16'h5555);
    repeat (3) @(negedge CLK);
    rst = 1'b1;
    @(negedge CLK);
    checks++;
    if (an !== 4'hF || seg !== 7'h7F || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL midreset_state: an=%h seg=%h fd=%b, want an=F seg=7F fd=0", an, seg, frame_done);
    end
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      repeat ((k == 0) ? 2 : 4) @(negedge CLK);
      ea    = 4'hF;
      ea[k] = 1'b0;
      es    = exp_seg(16'h0, k, 4'h0);
      checks++;
      if (an !== ea || seg !== es) begin
        errors++;
        $display("FAIL midreset_restart d%0d: an=%h seg=%h, want an=%h seg=%h", k, an, seg, ea, es);
      end
    end
    wait_fd(to);
    push_frame(16'h0000, 4'h0);
    capture(3);
    for (int k = 0; k < 4; k++) begin
      e = exp_q.pop_front();
      checks++;
      if (cap_an[k] !== e.an || cap_seg[k] !== e.seg) begin
        errors++;
        $display("FAIL midreset_discard d%0d: an=%h seg=%h, want an=%h seg=%h", k, cap_an[k], cap_seg[k], e.an, e.seg);
      end
    end
  endtask

  task automatic test_lead_zero;
    bit          to;
    slot_t       e;
    logic [15:0] vals[2];
    vals[0] = 16'h0050;
    vals[1] = 16'h0000;
    for (int v = 0; v < 2; v++) begin
      pulse_load(vals[v]);
      wait_fd(to);
      checks++;
      if (to) begin
        errors++;
        $display("FAIL lead_zero_timeout v%0d: frame_done=0, want 1", v);
      end
      push_frame(vals[v], 4'h0);
      capture(3);
      for (int k = 0; k < 4; k++) begin
        e = exp_q.pop_front();
        checks++;
        if (cap_an[k] !== e.an || cap_seg[k] !== e.seg) begin
          errors++;
          $display("FAIL lead_zero %h d%0d: an=%h seg=%h, want an=%h seg=%h",
                   vals[v], k, cap_an[k], cap_seg[k], e.an, e.seg);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_mid_frame();
    test_blank();
    test_last_wins();
    test_back_to_back();
    test_reset_mid_frame();
    test_lead_zero();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
